// File: rtl/disp_pkg.sv
`default_nettype none
// =============================================================================
// Module      : disp_pkg
// Description : Shared encodings and helpers for the display conversion scheduler.
// Revision    : 1.0 - initial release
// =============================================================================
package disp_pkg;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_store = 2'd3;

    localparam logic [1:0] c_slot_a = 2'd0;
    localparam logic [1:0] c_slot_b = 2'd1;
    localparam logic [1:0] c_slot_r = 2'd2;

    localparam int c_bcd2_w = 8;
    localparam int c_bcd4_w = 16;

    // Double-dabble correction: any digit of 5 or more gets +3 before the shift.
    function automatic logic [c_bcd4_w-1:0] bcd_add3(input logic [c_bcd4_w-1:0] v);
        logic [c_bcd4_w-1:0] r;
        r = v;
        for (int i = 0; i < c_bcd4_w / 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] slot_rotate(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            c_slot_a: n = c_slot_b;
            c_slot_b: n = c_slot_r;
            default:  n = c_slot_a;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// =============================================================================
// Module      : bin2bcd_seq
// Description : Sequential shift-and-add-3 binary to 4-digit BCD converter.
// Revision    : 1.0 - initial release
// =============================================================================
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int BIN_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic [c_bcd4_w-1:0] bcd,
    output logic                done
);

    localparam int                   c_cnt_w    = $clog2(BIN_W + 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_init = c_cnt_w'(BIN_W);
    localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);

    logic [BIN_W-1:0]          r_bin;
    logic [c_bcd4_w-1:0]       r_bcd;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [c_bcd4_w-1:0]       w_adj;
    logic [c_bcd4_w+BIN_W-1:0] w_shift;

    assign w_adj   = bcd_add3(r_bcd);
    assign w_shift = {w_adj, r_bin} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_bin <= bin;
            r_bcd <= '0;
            r_cnt <= c_cnt_init;
        end else if (r_cnt != '0) begin
            r_bcd <= w_shift[c_bcd4_w+BIN_W-1:BIN_W];
            r_bin <= w_shift[BIN_W-1:0];
            r_cnt <= r_cnt - c_cnt_one;
        end
    end

    assign bcd  = r_bcd;
    // High during the final shift cycle; bcd is complete on the following cycle.
    assign done = (r_cnt == c_cnt_one);

endmodule
`default_nettype wire

// File: rtl/disp_conv_sched.sv
`default_nettype none
// =============================================================================
// Module      : disp_conv_sched
// Description : Time-shares one BCD converter among operand A, B and ALU result.
// Revision    : 1.0 - initial release
// =============================================================================
module disp_conv_sched
    import disp_pkg::*;
#(
    parameter int width = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [width-1:0]    a,
    input  logic [width-1:0]    b,
    input  logic [2*width-1:0]  result,
    input  logic                err,
    input  logic                res_stb,
    input  logic                freeze,
    output logic [c_bcd2_w-1:0] bcd_a,
    output logic [c_bcd2_w-1:0] bcd_b,
    output logic [c_bcd4_w-1:0] bcd_r,
    output logic                sgn_r,
    output logic                ovf_r,
    output logic [2:0]          valid,
    output logic                busy
);

    localparam int c_bin_w = 2 * width;

    logic [1:0]          r_state;
    logic [1:0]          r_slot;
    logic [1:0]          r_rr;
    logic                r_pending;
    logic                r_sgn_hold;
    logic                r_ovf_hold;
    logic [c_bcd2_w-1:0] r_bcd_a;
    logic [c_bcd2_w-1:0] r_bcd_b;
    logic [c_bcd4_w-1:0] r_bcd_r;
    logic                r_sgn_r;
    logic                r_ovf_r;
    logic [2:0]          r_valid;

    logic [1:0]          w_next_slot;
    logic                w_advance;
    logic [c_bin_w-1:0]  w_mag;
    logic [c_bin_w-1:0]  w_bin;
    logic                w_start;
    logic                w_done;
    logic [c_bcd4_w-1:0] w_bcd;

    // The pointer only moves when the rotation slot itself is served, so a
    // priority R conversion leaves the rotation where it was.
    assign w_next_slot = r_pending ? c_slot_r : r_rr;
    assign w_advance   = (w_next_slot == r_rr);

    assign w_mag = result[c_bin_w-1] ? -result : result;

    always_comb begin
        w_bin = '0;
        case (r_slot)
            c_slot_a: w_bin = c_bin_w'(a);
            c_slot_b: w_bin = c_bin_w'(b);
            default:  w_bin = w_mag;
        endcase
    end

    assign w_start = (r_state == c_st_load);

    bin2bcd_seq #(
        .BIN_W (c_bin_w)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (w_bin),
        .bcd   (w_bcd),
        .done  (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_slot     <= c_slot_a;
            r_rr       <= c_slot_a;
            r_pending  <= 1'b0;
            r_sgn_hold <= 1'b0;
            r_ovf_hold <= 1'b0;
            r_bcd_a    <= '0;
            r_bcd_b    <= '0;
            r_bcd_r    <= '0;
            r_sgn_r    <= 1'b0;
            r_ovf_r    <= 1'b0;
            r_valid    <= 3'b000;
        end else begin
            if (res_stb) begin
                r_pending <= 1'b1;
            end else if (r_state == c_st_load && r_slot == c_slot_r) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                c_st_idle: begin
                    if (!freeze) begin
                        r_state <= c_st_load;
                        r_slot  <= w_next_slot;
                        if (w_advance) begin
                            r_rr <= slot_rotate(r_rr);
                        end
                    end
                end
                c_st_load: begin
                    if (r_slot == c_slot_r) begin
                        r_sgn_hold <= result[c_bin_w-1];
                        r_ovf_hold <= err;
                    end
                    r_state <= c_st_shift;
                end
                c_st_shift: begin
                    if (w_done) begin
                        r_state <= c_st_store;
                    end
                end
                default: begin
                    case (r_slot)
                        c_slot_a: begin
                            r_bcd_a    <= w_bcd[c_bcd2_w-1:0];
                            r_valid[0] <= 1'b1;
                        end
                        c_slot_b: begin
                            r_bcd_b    <= w_bcd[c_bcd2_w-1:0];
                            r_valid[1] <= 1'b1;
                        end
                        default: begin
                            r_bcd_r    <= w_bcd;
                            r_sgn_r    <= r_sgn_hold;
                            r_ovf_r    <= r_ovf_hold;
                            r_valid[2] <= 1'b1;
                        end
                    endcase
                    if (freeze) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_state <= c_st_load;
                        r_slot  <= w_next_slot;
                        if (w_advance) begin
                            r_rr <= slot_rotate(r_rr);
                        end
                    end
                end
            endcase
        end
    end

    assign bcd_a = r_bcd_a;
    assign bcd_b = r_bcd_b;
    assign bcd_r = r_bcd_r;
    assign sgn_r = r_sgn_r;
    assign ovf_r = r_ovf_r;
    assign valid = r_valid;
    assign busy  = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_disp_conv_sched.sv
`default_nettype none
// =============================================================================
// Module      : tb_disp_conv_sched
// Description : Directed and randomized self-checking bench for disp_conv_sched.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_disp_conv_sched;

    localparam int W  = 6;
    localparam int BW = 2 * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [BW-1:0] result = '0;
    logic          err = 1'b0;
    logic          res_stb = 1'b0;
    logic          freeze = 1'b0;
    logic [7:0]    bcd_a;
    logic [7:0]    bcd_b;
    logic [15:0]   bcd_r;
    logic          sgn_r;
    logic          ovf_r;
    logic [2:0]    valid;
    logic          busy;

    disp_conv_sched #(
        .width (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .result  (result),
        .err     (err),
        .res_stb (res_stb),
        .freeze  (freeze),
        .bcd_a   (bcd_a),
        .bcd_b   (bcd_b),
        .bcd_r   (bcd_r),
        .sgn_r   (sgn_r),
        .ovf_r   (ovf_r),
        .valid   (valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each conversion is a timeline of k = 0 (load),
    // 1..BW (shifting), BW+1 (store); slots 0=A, 1=B, 2=R.
    bit          m_active;
    int          m_k;
    int          m_slot;
    int          m_rr;
    bit          m_pend;
    bit          m_pend_old;
    bit          m_load_r;
    int          m_val;
    bit          m_sgn_h;
    bit          m_ovf_h;
    logic [7:0]  m_bcd_a;
    logic [7:0]  m_bcd_b;
    logic [15:0] m_bcd_r;
    bit          m_sgn;
    bit          m_ovf;
    logic [2:0]  m_valid;

    function automatic logic [15:0] dec4(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int magnitude(input logic [BW-1:0] r);
        if (r[BW-1]) return (1 << BW) - int'(r);
        return int'(r);
    endfunction

    task automatic model_reset();
        m_active = 0; m_k = 0; m_slot = 0; m_rr = 0; m_pend = 0;
        m_sgn_h = 0; m_ovf_h = 0; m_val = 0;
        m_bcd_a = '0; m_bcd_b = '0; m_bcd_r = '0;
        m_sgn = 0; m_ovf = 0; m_valid = 3'b000;
    endtask

    task automatic model_begin(input bit pend);
        m_slot   = pend ? 2 : m_rr;
        if (m_slot == m_rr) m_rr = (m_rr + 1) % 3;
        m_active = 1;
        m_k      = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            m_pend_old = m_pend;
            m_load_r   = m_active && (m_k == 0) && (m_slot == 2);
            if (!m_active) begin
                if (!freeze) model_begin(m_pend_old);
            end else if (m_k == 0) begin
                if (m_slot == 0)      m_val = int'(a);
                else if (m_slot == 1) m_val = int'(b);
                else begin
                    m_val   = magnitude(result);
                    m_sgn_h = result[BW-1];
                    m_ovf_h = err;
                end
                m_k = 1;
            end else if (m_k <= BW) begin
                m_k++;
            end else begin
                if (m_slot == 0) begin
                    m_bcd_a = 8'(dec4(m_val)); m_valid[0] = 1'b1;
                end else if (m_slot == 1) begin
                    m_bcd_b = 8'(dec4(m_val)); m_valid[1] = 1'b1;
                end else begin
                    m_bcd_r = dec4(m_val); m_sgn = m_sgn_h; m_ovf = m_ovf_h; m_valid[2] = 1'b1;
                end
                if (freeze) m_active = 0;
                else        model_begin(m_pend_old);
            end
            if (res_stb)       m_pend = 1;
            else if (m_load_r) m_pend = 0;
        end
    endtask

    task automatic check_all();
        check_eq("bcd_a", 32'(bcd_a), 32'(m_bcd_a));
        check_eq("bcd_b", 32'(bcd_b), 32'(m_bcd_b));
        check_eq("bcd_r", 32'(bcd_r), 32'(m_bcd_r));
        check_eq("sgn_r", 32'(sgn_r), 32'(m_sgn));
        check_eq("ovf_r", 32'(ovf_r), 32'(m_ovf));
        check_eq("valid", 32'(valid), 32'(m_valid));
        check_eq("busy",  32'(busy),  32'(m_active));
    endtask

    // Inputs are driven at the falling edge, sampled by DUT and model at the
    // rising edge, and outputs compared at the next falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        step(3);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_busy",  32'(busy),  32'd0);

        // Power-up sequence A, B, R
        rst = 1'b0; a = 6'd45; b = 6'd7; result = 12'd315; err = 1'b0;
        step(14);
        check_eq("a_edge14", 32'(bcd_a), 32'h00);
        step(1);
        check_eq("a_edge15", 32'(bcd_a), 32'h45);
        step(14);
        check_eq("b_edge29", 32'(bcd_b), 32'h07);
        step(14);
        check_eq("r_edge43", 32'(bcd_r), 32'h0315);
        check_eq("sgn_edge43", 32'(sgn_r), 32'd0);
        check_eq("valid_all", 32'(valid), 32'h7);

        // Negative results
        result = 12'hF9C;
        step(42);
        check_eq("r_neg100", 32'(bcd_r), 32'h0100);
        check_eq("sgn_neg100", 32'(sgn_r), 32'd1);
        check_eq("ovf_neg100", 32'(ovf_r), 32'd0);
        result = 12'h800;
        step(42);
        check_eq("r_min", 32'(bcd_r), 32'h2048);
        check_eq("sgn_min", 32'(sgn_r), 32'd1);

        // Overflow flag captured at R load only
        result = 12'd63; err = 1'b1;
        step(30);
        err = 1'b0; result = 12'd5;
        step(12);
        check_eq("ovf_set", 32'(ovf_r), 32'd1);
        check_eq("r_63", 32'(bcd_r), 32'h0063);
        step(20);
        check_eq("ovf_hold", 32'(ovf_r), 32'd1);
        step(22);
        check_eq("ovf_clr", 32'(ovf_r), 32'd0);
        check_eq("r_5", 32'(bcd_r), 32'h0005);

        // Priority R request during A shift
        a = 6'd33; b = 6'd22; result = 12'd77;
        step(3);
        res_stb = 1'b1;
        step(1);
        res_stb = 1'b0;
        step(10);
        check_eq("prio_a", 32'(bcd_a), 32'h33);
        step(14);
        check_eq("prio_r", 32'(bcd_r), 32'h0077);
        check_eq("prio_b_old", 32'(bcd_b), 32'h07);
        step(14);
        check_eq("prio_b_new", 32'(bcd_b), 32'h22);

        // Freeze mid-shift of R
        step(5);
        freeze = 1'b1; a = 6'd11;
        step(10);
        check_eq("frz_idle", 32'(busy), 32'd0);
        step(5);
        check_eq("frz_hold_a", 32'(bcd_a), 32'h33);
        freeze = 1'b0;
        step(15);
        check_eq("frz_resume_a", 32'(bcd_a), 32'h11);

        // Reset during B shift
        rst = 1'b1;
        step(2);
        rst = 1'b0; a = 6'd5; b = 6'd9;
        step(15);
        check_eq("pre_rst_valid", 32'(valid), 32'h1);
        step(5);
        rst = 1'b1;
        step(1);
        check_eq("mid_rst_valid", 32'(valid), 32'h0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_a", 32'(bcd_a), 32'h00);
        rst = 1'b0;
        step(15);
        check_eq("restart_a", 32'(bcd_a), 32'h05);
        check_eq("restart_valid", 32'(valid), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 7))
                0:       result = 12'h800;
                1:       result = 12'hFFF;
                2:       result = 12'h000;
                default: result = BW'($urandom);
            endcase
            err     = 1'($urandom_range(0, 1));
            res_stb = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 79) == 0) freeze = ~freeze;
            rst     = ($urandom_range(0, 599) == 0);
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
